// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
//   Bundles the CPU instruction/data ports and the single-port SRAM macro pins
//   that meet at sram_port_arbiter.
//
//   slave  : arbiter view (takes CPU requests and SRAM_DO, drives the SRAM
//            pins, stalls and read data back to the CPU)
//   master : environment view (the CPU and the SRAM macro together)
//
//   CPU instruction port : IM_req, IM_read, instr_addr -> instr_in, IM_stall
//   CPU data port        : DM_req, DM_read, data_addr, data_write, data_out
//                          -> data_in, DM_stall
//   SRAM macro           : SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI
//                          <- SRAM_DO
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if #(
  parameter int ADDR_BITS  = 14,
  parameter int DATA_BITS  = 32,
  parameter int WRITE_BITS = 4
);
  logic                  IM_req;
  logic                  IM_read;
  logic [ADDR_BITS-1:0]  instr_addr;
  logic                  DM_req;
  logic                  DM_read;
  logic [ADDR_BITS-1:0]  data_addr;
  logic [WRITE_BITS-1:0] data_write;
  logic [DATA_BITS-1:0]  data_out;
  logic [DATA_BITS-1:0]  instr_in;
  logic [DATA_BITS-1:0]  data_in;
  logic                  IM_stall;
  logic                  DM_stall;
  logic                  SRAM_CS;
  logic                  SRAM_OE;
  logic [WRITE_BITS-1:0] SRAM_WEB;
  logic [ADDR_BITS-1:0]  SRAM_A;
  logic [DATA_BITS-1:0]  SRAM_DI;
  logic [DATA_BITS-1:0]  SRAM_DO;

  modport slave (
    input  IM_req, IM_read, instr_addr,
    input  DM_req, DM_read, data_addr, data_write, data_out,
    input  SRAM_DO,
    output instr_in, data_in, IM_stall, DM_stall,
    output SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI
  );

  modport master (
    output IM_req, IM_read, instr_addr,
    output DM_req, DM_read, data_addr, data_write, data_out,
    output SRAM_DO,
    input  instr_in, data_in, IM_stall, DM_stall,
    input  SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one single-port synchronous SRAM between the CPU instruction-fetch
//   port and data port. Every access takes two cycles: an issue cycle in IDLE
//   where the winner drives the SRAM pins combinationally, then a wait cycle
//   in which SRAM_DO is returned to the granted port and captured into a hold
//   register so the CPU sees stable data between accesses.
//
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : sram_port_arbiter_if.slave (CPU ports + SRAM pins)
//
//   Stalls are combinational: a port stalls whenever it requests and is not
//   in its own wait (completion) cycle.
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_BITS  = 14,
  parameter int DATA_BITS  = 32,
  parameter int WRITE_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  sram_port_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IM_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

  // last_grant encoding: 0 = instruction port, 1 = data port
  localparam logic GRANT_IM = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  state_t                state_p1, state_nxt;
  logic                  last_grant_p1, last_grant_nxt;
  logic                  dm_rd_p1, dm_rd_nxt;
  logic [DATA_BITS-1:0]  instr_hold_p1;
  logic [DATA_BITS-1:0]  data_hold_p1;

  logic im_want, dm_want, im_win, dm_win;

  // An instruction request only counts when qualified by IM_read.
  assign im_want = bus.IM_req & bus.IM_read;
  assign dm_want = bus.DM_req;

  // On a collision the port that did not win last time goes first.
  assign dm_win = dm_want & (~im_want | (last_grant_p1 == GRANT_IM));
  assign im_win = im_want & ~dm_win;

  // ---- stage p0 -> p1: issue cycle decode / SRAM pin drive ----
  always_comb begin
    state_nxt      = state_p1;
    last_grant_nxt = last_grant_p1;
    dm_rd_nxt      = dm_rd_p1;
    bus.SRAM_CS    = 1'b0;
    bus.SRAM_OE    = 1'b0;
    bus.SRAM_WEB   = '1;
    bus.SRAM_A     = bus.instr_addr;
    bus.SRAM_DI    = bus.data_out;

    unique case (state_p1)
      IDLE: begin
        if (dm_win) begin
          bus.SRAM_CS    = 1'b1;
          bus.SRAM_A     = bus.data_addr;
          bus.SRAM_OE    = bus.DM_read;
          bus.SRAM_WEB   = bus.DM_read ? {WRITE_BITS{1'b1}} : bus.data_write;
          state_nxt      = DM_WAIT;
          last_grant_nxt = GRANT_DM;
          dm_rd_nxt      = bus.DM_read;
        end else if (im_win) begin
          bus.SRAM_CS    = 1'b1;
          bus.SRAM_A     = bus.instr_addr;
          bus.SRAM_OE    = 1'b1;
          state_nxt      = IM_WAIT;
          last_grant_nxt = GRANT_IM;
        end
      end
      IM_WAIT: begin
        bus.SRAM_OE = 1'b1;
        state_nxt   = IDLE;
      end
      DM_WAIT: begin
        bus.SRAM_OE = dm_rd_p1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Reset gates the macro pins immediately so an in-flight write can never
    // commit on the edge where reset is sampled.
    if (rst) begin
      bus.SRAM_CS  = 1'b0;
      bus.SRAM_OE  = 1'b0;
      bus.SRAM_WEB = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1      <= IDLE;
      last_grant_p1 <= GRANT_IM;
      dm_rd_p1      <= 1'b0;
    end else begin
      state_p1      <= state_nxt;
      last_grant_p1 <= last_grant_nxt;
      dm_rd_p1      <= dm_rd_nxt;
    end
  end

  // ---- stage p1: wait cycle, SRAM_DO returned and captured ----
  // The hold registers are architecturally visible after reset, so they are
  // cleared along with the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_hold_p1 <= '0;
      data_hold_p1  <= '0;
    end else begin
      if (state_p1 == IM_WAIT)
        instr_hold_p1 <= bus.SRAM_DO;
      if (state_p1 == DM_WAIT && dm_rd_p1)
        data_hold_p1  <= bus.SRAM_DO;
    end
  end

  assign bus.instr_in = (state_p1 == IM_WAIT) ? bus.SRAM_DO : instr_hold_p1;
  // Writes leave data_in untouched, so the bypass applies to reads only.
  assign bus.data_in  = (state_p1 == DM_WAIT && dm_rd_p1) ? bus.SRAM_DO : data_hold_p1;

  assign bus.IM_stall = bus.IM_req & (state_p1 != IM_WAIT);
  assign bus.DM_stall = bus.DM_req & (state_p1 != DM_WAIT);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter with a behavioural single-port SRAM
//   (registered read, active-low byte writes). Inputs change 1 ns after the
//   rising edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int AB = 14;
  localparam int DB = 32;
  localparam int WB = 4;

  logic clk;
  logic rst;

  int checks;
  int failures;

  sram_port_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .WRITE_BITS(WB)) bus ();

  sram_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .WRITE_BITS(WB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: read data appears the cycle after the address edge.
  logic [DB-1:0] mem [0:(1<<AB)-1];

  always @(posedge clk) begin
    if (bus.SRAM_CS) begin
      bus.SRAM_DO <= mem[bus.SRAM_A];
      for (int b = 0; b < WB; b++)
        if (!bus.SRAM_WEB[b])
          mem[bus.SRAM_A][8*b +: 8] = bus.SRAM_DI[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.IM_req     = 1'b0;
    bus.IM_read    = 1'b0;
    bus.instr_addr = '0;
    bus.DM_req     = 1'b0;
    bus.DM_read    = 1'b0;
    bus.data_addr  = '0;
    bus.data_write = '1;
    bus.data_out   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_bus();
    bus.IM_req  = 1'b1;
    bus.IM_read = 1'b1;
    cyc();
    chk("rst_cs",      32'(bus.SRAM_CS),  32'd0);
    chk("rst_oe",      32'(bus.SRAM_OE),  32'd0);
    chk("rst_web",     32'(bus.SRAM_WEB), 32'hf);
    chk("rst_imstall", 32'(bus.IM_stall), 32'd1);
    chk("rst_instr",   bus.instr_in,      32'd0);
    chk("rst_data",    bus.data_in,       32'd0);
    idle_bus();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_dmstall", 32'(bus.DM_stall), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_bus();
    bus.SRAM_DO = '0;
    mem[14'h10] = 32'h0000_0013;
    mem[14'h20] = 32'h0102_0304;
    mem[14'h30] = 32'hDEAD_BEEF;
    mem[14'h31] = 32'h1111_2222;
    mem[14'h32] = 32'hCAFE_F00D;
    mem[14'h40] = 32'h1234_5678;
    mem[14'h00] = 32'hA000_0000;
    mem[14'h01] = 32'hA000_0001;
    mem[14'h02] = 32'hA000_0002;
    mem[14'h05] = 32'h55AA_55AA;
    cyc();

    do_reset();

    // Uncontended instruction read
    bus.IM_req = 1'b1; bus.IM_read = 1'b1; bus.instr_addr = 14'h10;
    #1;
    chk("im_cs0",    32'(bus.SRAM_CS),  32'd1);
    chk("im_a0",     32'(bus.SRAM_A),   32'h10);
    chk("im_oe0",    32'(bus.SRAM_OE),  32'd1);
    chk("im_stall0", 32'(bus.IM_stall), 32'd1);
    cyc();
    chk("im_stall1", 32'(bus.IM_stall), 32'd0);
    chk("im_data1",  bus.instr_in,      32'h0000_0013);
    chk("im_cs1",    32'(bus.SRAM_CS),  32'd0);
    idle_bus();
    cyc();
    chk("im_hold",   bus.instr_in,      32'h0000_0013);

    // Collision right after reset: DM first, then IM wins the re-collision
    do_reset();
    bus.IM_req = 1'b1; bus.IM_read = 1'b1; bus.instr_addr = 14'h31;
    bus.DM_req = 1'b1; bus.DM_read = 1'b1; bus.data_addr  = 14'h30;
    #1;
    chk("col_a0",    32'(bus.SRAM_A),   32'h30);
    chk("col_ims0",  32'(bus.IM_stall), 32'd1);
    chk("col_dms0",  32'(bus.DM_stall), 32'd1);
    cyc();
    chk("col_d1",    bus.data_in,       32'hDEAD_BEEF);
    chk("col_dms1",  32'(bus.DM_stall), 32'd0);
    chk("col_ims1",  32'(bus.IM_stall), 32'd1);
    chk("col_cs1",   32'(bus.SRAM_CS),  32'd0);
    bus.data_addr = 14'h32;
    cyc();
    chk("col_a2",    32'(bus.SRAM_A),   32'h31);
    chk("col_cs2",   32'(bus.SRAM_CS),  32'd1);
    chk("col_ims2",  32'(bus.IM_stall), 32'd1);
    chk("col_dms2",  32'(bus.DM_stall), 32'd1);
    chk("col_dh2",   bus.data_in,       32'hDEAD_BEEF);
    cyc();
    chk("col_i3",    bus.instr_in,      32'h1111_2222);
    chk("col_ims3",  32'(bus.IM_stall), 32'd0);
    chk("col_dms3",  32'(bus.DM_stall), 32'd1);
    bus.IM_req = 1'b0; bus.IM_read = 1'b0;
    cyc();
    chk("col_a4",    32'(bus.SRAM_A),   32'h32);
    chk("col_dms4",  32'(bus.DM_stall), 32'd1);
    cyc();
    chk("col_d5",    bus.data_in,       32'hCAFE_F00D);
    chk("col_dms5",  32'(bus.DM_stall), 32'd0);
    idle_bus();
    cyc();

    // Partial byte write, then readback
    bus.DM_req = 1'b1; bus.DM_read = 1'b0; bus.data_addr = 14'h20;
    bus.data_out = 32'hAABB_CCDD; bus.data_write = 4'b1110;
    #1;
    chk("wr_cs0",    32'(bus.SRAM_CS),  32'd1);
    chk("wr_web0",   32'(bus.SRAM_WEB), 32'he);
    chk("wr_di0",    bus.SRAM_DI,       32'hAABB_CCDD);
    chk("wr_oe0",    32'(bus.SRAM_OE),  32'd0);
    chk("wr_dms0",   32'(bus.DM_stall), 32'd1);
    cyc();
    chk("wr_web1",   32'(bus.SRAM_WEB), 32'hf);
    chk("wr_cs1",    32'(bus.SRAM_CS),  32'd0);
    chk("wr_dms1",   32'(bus.DM_stall), 32'd0);
    chk("wr_din1",   bus.data_in,       32'hCAFE_F00D);
    idle_bus();
    cyc();
    bus.DM_req = 1'b1; bus.DM_read = 1'b1; bus.data_addr = 14'h20;
    cyc();
    chk("rb_word",   bus.data_in,       32'h0102_03DD);
    chk("rb_byte0",  32'(bus.data_in[7:0]), 32'hDD);
    idle_bus();
    cyc();

    // Write with all enables high: a 2-cycle no-op
    bus.DM_req = 1'b1; bus.DM_read = 1'b0; bus.data_addr = 14'h20;
    bus.data_out = 32'h0; bus.data_write = 4'hf;
    #1;
    chk("nop_cs0",   32'(bus.SRAM_CS),  32'd1);
    chk("nop_web0",  32'(bus.SRAM_WEB), 32'hf);
    chk("nop_dms0",  32'(bus.DM_stall), 32'd1);
    cyc();
    chk("nop_dms1",  32'(bus.DM_stall), 32'd0);
    chk("nop_din1",  bus.data_in,       32'h0102_03DD);
    idle_bus();
    cyc();

    // Back-to-back instruction reads
    bus.IM_req = 1'b1; bus.IM_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.instr_addr = AB'(i);
      #1;
      chk("b2b_cs_on",  32'(bus.SRAM_CS),  32'd1);
      chk("b2b_a",      32'(bus.SRAM_A),   32'(i));
      chk("b2b_stall",  32'(bus.IM_stall), 32'd1);
      cyc();
      chk("b2b_cs_off", 32'(bus.SRAM_CS),  32'd0);
      chk("b2b_done",   32'(bus.IM_stall), 32'd0);
      chk("b2b_data",   bus.instr_in,      32'hA000_0000 + 32'(i));
      cyc();
    end
    idle_bus();
    #1;
    chk("b2b_hold",  bus.instr_in,      32'hA000_0002);

    // Reset during a read wait cycle
    bus.DM_req = 1'b1; bus.DM_read = 1'b1; bus.data_addr = 14'h30;
    cyc();
    rst = 1'b1;
    #1;
    chk("rr_cs",     32'(bus.SRAM_CS),  32'd0);
    chk("rr_oe",     32'(bus.SRAM_OE),  32'd0);
    cyc();
    chk("rr_dms",    32'(bus.DM_stall), 32'd1);
    chk("rr_dhold",  bus.data_in,       32'd0);
    chk("rr_ihold",  bus.instr_in,      32'd0);
    // Reset held through what would be a write's grant cycle
    bus.DM_read = 1'b0; bus.data_addr = 14'h40;
    bus.data_out = 32'h5555_5555; bus.data_write = 4'h0;
    #1;
    chk("rw_web",    32'(bus.SRAM_WEB), 32'hf);
    chk("rw_cs",     32'(bus.SRAM_CS),  32'd0);
    cyc();
    rst = 1'b0;
    bus.DM_read = 1'b1; bus.data_write = 4'hf;
    #1;
    chk("rw_idle_cs", 32'(bus.SRAM_CS), 32'd1);
    chk("rw_idle_a",  32'(bus.SRAM_A),  32'h40);
    cyc();
    chk("rw_nocommit", bus.data_in,     32'h1234_5678);
    idle_bus();
    cyc();

    // DM pulse while IM is in its wait cycle is discarded
    bus.IM_req = 1'b1; bus.IM_read = 1'b1; bus.instr_addr = 14'h05;
    cyc();
    bus.DM_req = 1'b1; bus.DM_read = 1'b1; bus.data_addr = 14'h07;
    #1;
    chk("pl_cs1",    32'(bus.SRAM_CS),  32'd0);
    chk("pl_dms1",   32'(bus.DM_stall), 32'd1);
    chk("pl_i1",     bus.instr_in,      32'h55AA_55AA);
    cyc();
    idle_bus();
    #1;
    chk("pl_cs2",    32'(bus.SRAM_CS),  32'd0);
    chk("pl_dms2",   32'(bus.DM_stall), 32'd0);
    cyc();
    chk("pl_cs3",    32'(bus.SRAM_CS),  32'd0);
    chk("pl_din3",   bus.data_in,       32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
